// File: rtl/tt_response_checker.sv
// Truth-table response checker: walks vectors 0..7 with per-vector dwell, compares {Y1,Y2}.
// Optional MISR signature on sampled responses enabled by macro TT_CHECKER_MISR_EN.
module tt_response_checker #(
    parameter logic [7:0] EXP_Y1 = 8'hE8,
    parameter logic [7:0] EXP_Y2 = 8'h96,
    parameter logic [3:0] DWELL0 = 4'd7,
    parameter logic [3:0] DWELL1 = 4'd2,
    parameter logic [3:0] DWELL2 = 4'd9,
    parameter logic [3:0] DWELL3 = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] resp_y,
    output logic [2:0] stim_abc,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_vld,
    output logic [2:0] fail_idx,
    output logic [7:0] sig
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       fail_vld_q, fail_vld_d;
    logic [2:0] fail_idx_q, fail_idx_d;
    logic [2:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic       run_entry;
    logic       sample;
    logic [1:0] exp_pair;

    // Counter reload value; a dwell of 0 behaves as 1 (sample on first cycle).
    function automatic logic [3:0] dwell_load(input logic [1:0] sel);
        logic [3:0] d;
        unique case (sel)
            2'd0:    d = DWELL0;
            2'd1:    d = DWELL1;
            2'd2:    d = DWELL2;
            default: d = DWELL3;
        endcase
        return (d == 4'd0) ? 4'd0 : d - 4'd1;
    endfunction

    assign run_entry = ((state_q == StIdle) || (state_q == StDone)) && start;
    assign sample    = (state_q == StRun) && (cnt_q == 4'd0);
    assign exp_pair  = {EXP_Y1[idx_q], EXP_Y2[idx_q]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        fail_vld_d = fail_vld_q;
        fail_idx_d = fail_idx_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 3'd0;
                    cnt_d      = dwell_load(2'd0);
                    err_cnt_d  = 4'd0;
                    fail_vld_d = 1'b0;
                    fail_idx_d = 3'd0;
                    stim_d     = 3'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            StRun: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (resp_y != exp_pair) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                        if (!fail_vld_q) begin
                            fail_vld_d = 1'b1;
                            fail_idx_d = idx_q;
                        end
                    end
                    if (idx_q == 3'd7) begin
                        state_d = StDone;
                        stim_d  = 3'b111;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == 4'd0);
                    end else begin
                        // stim tracks idx so resp_y always belongs to the vector being sampled
                        idx_d  = idx_q + 3'd1;
                        stim_d = idx_q + 3'd1;
                        cnt_d  = dwell_load(idx_q[1:0] + 2'd1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            cnt_q      <= 4'd0;
            err_cnt_q  <= 4'd0;
            fail_vld_q <= 1'b0;
            fail_idx_q <= 3'd0;
            stim_q     <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            fail_vld_q <= fail_vld_d;
            fail_idx_q <= fail_idx_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

`ifdef TT_CHECKER_MISR_EN
    logic [7:0] sig_q, sig_d;
    logic       fb;

    assign fb = sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3];

    always_comb begin
        sig_d = sig_q;
        if (run_entry) begin
            sig_d = 8'hFF;
        end else if (sample) begin
            sig_d = {sig_q[6:0], fb} ^ {6'b0, resp_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 8'hFF;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 8'h00;
`endif

    assign stim_abc = stim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vld = fail_vld_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: behavioural unit-under-test tables, timing and result reference.
module tb_tt_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] resp_y;
    logic [2:0] stim_abc;
    logic       busy, done, pass, fail_vld;
    logic [3:0] err_cnt;
    logic [2:0] fail_idx;
    logic [7:0] sig;

    logic [7:0] m1, m2;
    int n_vec = 0;
    int n_err = 0;
    int dw[4] = '{7, 2, 9, 4};
    logic [7:0] prev_sig;

    localparam logic [7:0] GoldY1 = 8'hE8;
    localparam logic [7:0] GoldY2 = 8'h96;
`ifdef TT_CHECKER_MISR_EN
    localparam logic [7:0] SigRst = 8'hFF;
`else
    localparam logic [7:0] SigRst = 8'h00;
`endif

    always #5 clk = ~clk;

    // Combinational unit under test, described by its two truth tables.
    assign resp_y = {m1[stim_abc], m2[stim_abc]};

    tt_response_checker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .resp_y   (resp_y),
        .stim_abc (stim_abc),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vld (fail_vld),
        .fail_idx (fail_idx),
        .sig      (sig)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_errs(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] != GoldY1[i] || b[i] != GoldY2[i]) n++;
        end
        return n;
    endfunction

    function automatic int ref_first(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (a[i] != GoldY1[i] || b[i] != GoldY2[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [7:0] ref_sig(input logic [7:0] a, input logic [7:0] b);
`ifdef TT_CHECKER_MISR_EN
        logic [7:0] s = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {6'b0, a[i], b[i]};
        end
        return s;
`else
        return 8'h00 & (a | b);
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " stim"}, stim_abc, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
        check({tag, " fail_vld"}, fail_vld, 0);
        check({tag, " fail_idx"}, fail_idx, 0);
        check({tag, " sig"}, sig, SigRst);
    endtask

    // Pulse start, follow the run to DONE, then check timing, vector sequence and results.
    task automatic run_check(input string tag, input int s1, input int s2);
        int seq[$];
        int exp_seq[$];
        int done_cyc = -1;
        int bad = 0;
        int ne;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < dw[i % 4]; j++) exp_seq.push_back(i);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (done && done_cyc < 0) done_cyc = cyc;
            if (busy) seq.push_back(int'(stim_abc));
            if (done_cyc >= 0) break;
            start = (cyc == s1 || cyc == s2);
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < exp_seq.size(); k++) begin
            if (k >= seq.size() || seq[k] != exp_seq[k]) bad++;
        end
        ne = ref_errs(m1, m2);
        check({tag, " done_cycle"}, done_cyc, 45);
        check({tag, " busy_cycles"}, seq.size(), 44);
        check({tag, " vector_seq_errs"}, bad, 0);
        check({tag, " stim_done"}, stim_abc, 7);
        check({tag, " busy_done"}, busy, 0);
        check({tag, " err_cnt"}, err_cnt, ne);
        check({tag, " fail_vld"}, fail_vld, ne != 0);
        check({tag, " fail_idx"}, fail_idx, ref_first(m1, m2));
        check({tag, " pass"}, pass, ne == 0);
        check({tag, " sig"}, sig, ref_sig(m1, m2));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        m1 = GoldY1;
        m2 = GoldY2;
        #3;
        check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("idle10");

        run_check("golden", 0, 0);
        prev_sig = sig;
        repeat (5) @(negedge clk);
        check("done_hold", done, 1);
        check("pass_hold", pass, 1);

        run_check("golden_rerun", 0, 0);
        check("sig_repeat", sig, prev_sig);

        m2 = 8'h00;
        run_check("y2_sa0", 0, 0);

        m2 = GoldY2;
        run_check("start_while_busy", 3, 20);

        // Reset at cycle 15 of a faulty run, then a clean run from scratch.
        m2 = 8'h00;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_err", err_cnt, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        @(negedge clk) rst_n = 1'b1;
        m2 = GoldY2;
        run_check("post_reset", 0, 0);

        for (int r = 0; r < 6; r++) begin
            m1 = 8'($urandom);
            m2 = 8'($urandom);
            run_check($sformatf("rand%0d", r), int'($urandom_range(1, 43)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
